cheshire_reg_to_axi: RTL and testbench



---
 rtl/cheshire_pkg.sv | 102 ++++++++++
 rtl/cheshire_reg_to_axi.sv | 176 +++++++++++++++++
 tb/tb_cheshire_reg_to_axi.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cheshire_pkg.sv
// Shared cheshire typedefs: regbus a48/d32 and AXI a48/d64 master bundles.
// Also holds crossbar ID planning constants.
package cheshire_pkg;

  localparam int unsigned AXI_ID_W   = 2;
  localparam int unsigned AXI_ADDR_W = 48;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_USER_W = 1;

  localparam int unsigned REG2AXI_ID = 0;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_a48_d32_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_a48_d32_rsp_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [5:0]            atop;
    logic [AXI_USER_W-1:0] user;
  } axi_a48_aw_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } axi_d64_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [AXI_USER_W-1:0] user;
  } axi_a48_ar_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } axi_d64_r_t;

  typedef struct packed {
    axi_a48_aw_t aw;
    logic        aw_valid;
    axi_d64_w_t  w;
    logic        w_valid;
    logic        b_ready;
    axi_a48_ar_t ar;
    logic        ar_valid;
    logic        r_ready;
  } axi_a48_d64_mst_u0_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    logic       b_valid;
    axi_b_t     b;
    logic       r_valid;
    axi_d64_r_t r;
  } axi_a48_d64_mst_u0_resp_t;

endpackage

// File: rtl/cheshire_reg_to_axi.sv
// Regbus to AXI bridge: one single-beat 32-bit AXI transfer per regbus request.
// Only one transaction is ever outstanding.
module cheshire_reg_to_axi
  import cheshire_pkg::*;
#(
  parameter int unsigned AxiId = REG2AXI_ID,
  parameter type reg_req_t = reg_a48_d32_req_t,
  parameter type reg_rsp_t = reg_a48_d32_rsp_t,
  parameter type axi_req_t = axi_a48_d64_mst_u0_req_t,
  parameter type axi_rsp_t = axi_a48_d64_mst_u0_resp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output axi_req_t axi_req_o,
  input  axi_rsp_t axi_rsp_i,
  output logic     busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [47:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        misaligned;
  logic        hi_lane;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        b_hs;
  logic        r_hs;
  logic [31:0] r_lane;

  assign misaligned = addr_q[1:0] != 2'b00;
  assign hi_lane    = addr_q[2];

  assign aw_hs = axi_req_o.aw_valid & axi_rsp_i.aw_ready;
  assign w_hs  = axi_req_o.w_valid  & axi_rsp_i.w_ready;
  assign ar_hs = axi_req_o.ar_valid & axi_rsp_i.ar_ready;
  assign b_hs  = axi_req_o.b_ready  & axi_rsp_i.b_valid;
  assign r_hs  = axi_req_o.r_ready  & axi_rsp_i.r_valid;

  assign r_lane = hi_lane ? axi_rsp_i.r.data[63:32]
                          : axi_rsp_i.r.data[31:0];

  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user,
                        axi_rsp_i.r.id, axi_rsp_i.r.user};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (reg_req_i.valid) state_d = CHK;
      CHK: begin
        if (misaligned)   state_d = DONE;
        else if (write_q) state_d = WR_REQ;
        else              state_d = RD_REQ;
      end
      WR_REQ: begin
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs))
          state_d = WR_RSP;
      end
      WR_RSP: if (b_hs)  state_d = DONE;
      RD_REQ: if (ar_hs) state_d = RD_RSP;
      RD_RSP: if (r_hs)  state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, per-channel done flags and the response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (reg_req_i.valid) begin
            addr_q    <= reg_req_i.addr;
            write_q   <= reg_req_i.write;
            wdata_q   <= reg_req_i.wdata;
            wstrb_q   <= reg_req_i.wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        CHK: begin
          rdata_q <= '0;
          error_q <= misaligned;
        end
        WR_REQ: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        WR_RSP: begin
          if (b_hs) error_q <= axi_rsp_i.b.resp != AXI_RESP_OKAY;
        end
        RD_RSP: begin
          if (r_hs) begin
            rdata_q <= r_lane;
            error_q <= (axi_rsp_i.r.resp != AXI_RESP_OKAY)
                     | ~axi_rsp_i.r.last;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    axi_req_o = '0;

    axi_req_o.aw.id    = AXI_ID_W'(AxiId);
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.size  = AXI_SIZE_4B;
    axi_req_o.aw.burst = AXI_BURST_INCR;

    axi_req_o.w.data = {wdata_q, wdata_q};
    axi_req_o.w.strb = hi_lane ? {wstrb_q, 4'b0000}
                               : {4'b0000, wstrb_q};
    axi_req_o.w.last = 1'b1;

    axi_req_o.ar.id    = AXI_ID_W'(AxiId);
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.size  = AXI_SIZE_4B;
    axi_req_o.ar.burst = AXI_BURST_INCR;

    axi_req_o.aw_valid = (state_q == WR_REQ) & ~aw_done_q;
    axi_req_o.w_valid  = (state_q == WR_REQ) & ~w_done_q;
    axi_req_o.b_ready  = state_q == WR_RSP;
    axi_req_o.ar_valid = state_q == RD_REQ;
    axi_req_o.r_ready  = state_q == RD_RSP;

    reg_rsp_o = '0;
    if (state_q == DONE) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.rdata = rdata_q;
      reg_rsp_o.error = error_q;
    end

    busy_o = state_q != IDLE;
  end

endmodule

// File: tb/tb_cheshire_reg_to_axi.sv
// Bench for cheshire_reg_to_axi: directed and random regbus requests
// against a cycle-stepped AXI slave and a transaction-level reference.
module tb_cheshire_reg_to_axi;
  import cheshire_pkg::*;

  logic clk;
  logic rst_ni;
  reg_a48_d32_req_t         reg_req;
  reg_a48_d32_rsp_t         reg_rsp;
  axi_a48_d64_mst_u0_req_t  axi_req;
  axi_a48_d64_mst_u0_resp_t axi_rsp;
  logic busy;

  int errors = 0;
  int checks = 0;

  cheshire_reg_to_axi dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .reg_req_i (reg_req),
    .reg_rsp_o (reg_rsp),
    .axi_req_o (axi_req),
    .axi_rsp_i (axi_rsp),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One regbus request; cycle 0 is the first cycle valid is presented.
  task automatic run_txn(input logic [47:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int aw_d, input int w_d, input int ar_d,
                         input int rsp_d, input logic [1:0] resp,
                         input logic [63:0] rd64, input logic last);
    axi_a48_aw_t aw_cap, exp_aw;
    axi_d64_w_t  w_cap, exp_w;
    axi_a48_ar_t ar_cap, exp_ar;
    int aw_n, w_n, ar_n, aw_w, w_w, ar_w, rs_w, done_cyc, exp_lat;
    bit aw_seen, w_seen, ar_seen, aw_drop, w_drop, ar_drop;
    bit rs_pend, rs_issued, got, nack;
    logic [31:0] o_rdata, exp_rdata;
    logic o_err, exp_err, misal;

    aw_n = 0; w_n = 0; ar_n = 0; aw_w = 0; w_w = 0; ar_w = 0; rs_w = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0;
    aw_drop = 0; w_drop = 0; ar_drop = 0;
    rs_pend = 0; rs_issued = 0; got = 0; nack = 0;
    done_cyc = -1; o_rdata = '0; o_err = 1'b0;
    aw_cap = '0; w_cap = '0; ar_cap = '0;

    misal = (addr % 4) != 0;
    if (misal)   exp_err = 1'b1;
    else if (wr) exp_err = resp != 2'd0;
    else         exp_err = (resp != 2'd0) || !last;
    if (misal)
      exp_rdata = 32'h0;
    else
      exp_rdata = ((addr % 8) >= 4) ? 32'(rd64 / 64'h1_0000_0000)
                                    : 32'(rd64 % 64'h1_0000_0000);
    if (misal)   exp_lat = 2;
    else if (wr) exp_lat = 4 + ((aw_d > w_d) ? aw_d : w_d) + rsp_d;
    else         exp_lat = 4 + ar_d + rsp_d;

    exp_aw = '0;
    exp_aw.id = 2'(REG2AXI_ID);
    exp_aw.addr = addr;
    exp_aw.size = 3'd2;
    exp_aw.burst = 2'b01;
    exp_ar = '0;
    exp_ar.id = 2'(REG2AXI_ID);
    exp_ar.addr = addr;
    exp_ar.size = 3'd2;
    exp_ar.burst = 2'b01;
    exp_w = '0;
    exp_w.data = 64'(wdata) * 64'h1_0000_0001;
    exp_w.strb = ((addr % 8) >= 4) ? 8'(wstrb) * 8'd16 : 8'(wstrb);
    exp_w.last = 1'b1;

    reg_req.addr  = addr;
    reg_req.write = wr;
    reg_req.wdata = wdata;
    reg_req.wstrb = wstrb;
    reg_req.valid = 1'b1;

    for (int c = 0; c < 200 && !got; c++) begin
      if (reg_rsp.ready) begin
        got = 1;
        done_cyc = c;
        o_rdata = reg_rsp.rdata;
        o_err = reg_rsp.error;
        nack = axi_req.b_ready | axi_req.r_ready;
      end else begin
        axi_rsp.b_valid = 1'b0;
        axi_rsp.r_valid = 1'b0;
        if (rs_pend) begin
          if (rs_w >= rsp_d) begin
            if (wr) begin
              axi_rsp.b_valid = 1'b1;
              axi_rsp.b.resp = resp;
            end else begin
              axi_rsp.r_valid = 1'b1;
              axi_rsp.r.data = rd64;
              axi_rsp.r.resp = resp;
              axi_rsp.r.last = last;
            end
          end
          rs_w++;
          if ((axi_rsp.b_valid && axi_req.b_ready) ||
              (axi_rsp.r_valid && axi_req.r_ready))
            rs_pend = 0;
        end

        if (aw_seen && aw_n == 0 && !axi_req.aw_valid) aw_drop = 1;
        if (w_seen && w_n == 0 && !axi_req.w_valid) w_drop = 1;
        if (ar_seen && ar_n == 0 && !axi_req.ar_valid) ar_drop = 1;

        axi_rsp.aw_ready = axi_req.aw_valid && aw_w >= aw_d;
        axi_rsp.w_ready  = axi_req.w_valid && w_w >= w_d;
        axi_rsp.ar_ready = axi_req.ar_valid && ar_w >= ar_d;
        if (axi_req.aw_valid) begin aw_seen = 1; aw_w++; end
        if (axi_req.w_valid)  begin w_seen = 1;  w_w++;  end
        if (axi_req.ar_valid) begin ar_seen = 1; ar_w++; end
        if (axi_req.aw_valid && axi_rsp.aw_ready) begin
          aw_n++;
          aw_cap = axi_req.aw;
        end
        if (axi_req.w_valid && axi_rsp.w_ready) begin
          w_n++;
          w_cap = axi_req.w;
        end
        if (axi_req.ar_valid && axi_rsp.ar_ready) begin
          ar_n++;
          ar_cap = axi_req.ar;
        end

        if (!rs_issued &&
            ((wr && aw_n > 0 && w_n > 0) || (!wr && ar_n > 0))) begin
          rs_pend = 1;
          rs_issued = 1;
        end
        tick();
      end
    end

    chk("no_timeout", 128'(got), 128'(1));
    chk("latency", 128'(done_cyc), 128'(exp_lat));
    chk("error", 128'(o_err), 128'(exp_err));
    if (misal || !wr) chk("rdata", 128'(o_rdata), 128'(exp_rdata));
    chk("done_no_ack", 128'(nack), 128'(0));
    chk("aw_count", 128'(aw_n), 128'(wr && !misal));
    chk("w_count", 128'(w_n), 128'(wr && !misal));
    chk("ar_count", 128'(ar_n), 128'(!wr && !misal));
    chk("valid_hold", 128'({aw_drop, w_drop, ar_drop}), 128'(0));
    if (aw_n == 1) chk("aw_fields", 128'(aw_cap), 128'(exp_aw));
    if (w_n == 1)  chk("w_fields", 128'(w_cap), 128'(exp_w));
    if (ar_n == 1) chk("ar_fields", 128'(ar_cap), 128'(exp_ar));

    axi_rsp = '0;
    tick();
    reg_req.valid = 1'b0;
    chk("idle_after", 128'({busy, reg_rsp.ready, reg_rsp.rdata}), 128'(0));
    tick();
    chk("idle_stays", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [47:0] a;
    int hit;

    rst_ni = 1'b0;
    reg_req = '0;
    axi_rsp = '0;
    repeat (3) tick();
    chk("rst_valids", 128'({axi_req.aw_valid, axi_req.w_valid,
        axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready}), 128'(0));
    chk("rst_rsp", 128'({busy, reg_rsp.ready, reg_rsp.error,
        reg_rsp.rdata}), 128'(0));
    rst_ni = 1'b1;
    tick();

    axi_rsp.b_valid = 1'b1;
    axi_rsp.r_valid = 1'b1;
    tick();
    chk("idle_no_ack", 128'({axi_req.b_ready, axi_req.r_ready}), 128'(0));
    axi_rsp = '0;
    tick();

    run_txn(48'h7000_0004, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0,
            2'd0, 64'h0, 1'b1);
    run_txn(48'h7000_0000, 0, 32'h0, 4'h0, 0, 0, 0, 0,
            2'd0, 64'h1111_2222_3333_4444, 1'b1);
    run_txn(48'h7000_0008, 0, 32'h0, 4'h0, 0, 0, 0, 0,
            2'd0, 64'h1111_2222_3333_4444, 1'b1);
    run_txn(48'h7000_0002, 0, 32'h0, 4'h0, 0, 0, 0, 0,
            2'd0, 64'h1111_2222_3333_4444, 1'b1);
    run_txn(48'h7000_0010, 1, 32'h1234_5678, 4'h3, 5, 0, 0, 0,
            2'd3, 64'h0, 1'b1);
    run_txn(48'h7000_0014, 1, 32'hCAFE_F00D, 4'h0, 0, 3, 0, 1,
            2'd0, 64'h0, 1'b1);
    run_txn(48'h7000_0020, 0, 32'h0, 4'h0, 0, 0, 2, 1,
            2'd1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);

    // Reset while the bridge waits for R
    reg_req.addr = 48'h7000_0030;
    reg_req.write = 1'b0;
    reg_req.valid = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      axi_rsp.ar_ready = axi_req.ar_valid;
      if (axi_req.r_ready) hit = 1;
      else tick();
    end
    chk("reach_rd_rsp", 128'(hit), 128'(1));
    rst_ni = 1'b0;
    #1;
    chk("rst_async", 128'({axi_req.ar_valid, axi_req.r_ready, busy,
        reg_rsp.ready}), 128'(0));
    reg_req.valid = 1'b0;
    axi_rsp = '0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("rst_no_stale", 128'({busy, reg_rsp.ready}), 128'(0));
    run_txn(48'h7000_0034, 0, 32'h0, 4'h0, 0, 0, 0, 0,
            2'd0, 64'h5555_6666_7777_8888, 1'b1);

    for (int n = 0; n < 40; n++) begin
      a = {16'($urandom), $urandom};
      a[1:0] = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      run_txn(a, 1'($urandom_range(1)), $urandom, 4'($urandom),
              $urandom_range(3), $urandom_range(3), $urandom_range(3),
              $urandom_range(3),
              $urandom_range(1) ? 2'd0 : 2'($urandom_range(3)),
              {$urandom, $urandom}, $urandom_range(7) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
